dma_addr_gen: RTL and testbench
===============================

Name: dma_addr_gen

Overview:
- Upstream command/address generator for the DMA signal register stage.
- Accepts one transfer command: start address, beat count and direction.
- Expands it into a registered per-beat stream: valid, end-of-transfer, act1 (read) / act2 (write) flags and a 64-bit address.
- The signal register stage samples every output every cycle.

Parameters:
- ADDR_W, 64, address width; matches the 64-bit addr_COM bus.
- LEN_W, 16, beat-count width.
- STRIDE, 8, address increment per beat, in bytes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  generator can accept a command.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  number of beats.
- cmd_dir  in  2  01 = read (act1), 10 = write (act2); 00 and 11 are illegal.
- stall  in  1  downstream backpressure; freezes beat issue.
- abort  in  1  synchronous cancel of the current transfer.
- valid_out  out  1  beat valid; feeds valid_IN.
- end_out  out  1  last beat of the transfer; feeds End_IN.
- act1_out  out  1  read transfer active; feeds act1_IN.
- act2_out  out  1  write transfer active; feeds act2_IN.
- addr_com  out  ADDR_W  beat address; feeds addr_COM.
- busy  out  1  transfer in progress.
- err  out  1  one-cycle pulse: command rejected.

Behaviour:
- Reset (async, active-high): state IDLE.
  - cmd_ready = 1.
  - valid_out, end_out, act1_out, act2_out, busy, err = 0; addr_com = 0.
  - Beat counter and address register cleared.
- All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready = 1; acceptance is cmd_valid & cmd_ready at a rising edge.
  - Illegal command (cmd_len == 0 or cmd_dir is 00/11): err = 1 for exactly one cycle after the edge; state stays IDLE; no beats issued.
  - Legal command: latch addr, len and dir; go to RUN; busy = 1 and cmd_ready = 0 from the next cycle.
- RUN, each edge with stall = 0 issues one beat:
  - valid_out = 1; addr_com = current address.
  - act1_out / act2_out per the latched dir; exactly one of them is set.
  - Address += STRIDE; the sum wraps modulo 2^ADDR_W with no error.
  - Remaining count decrements.
  - The beat with remaining == 1 also sets end_out = 1; next state is DONE.
- RUN with stall = 1:
  - valid_out = 0 and end_out = 0.
  - addr_com, counter and act flags hold.
  - No beat is lost or duplicated.
- Latency: command accepted at edge k; the first beat is visible after edge k+1 if stall = 0 at k+1.
- DONE (one cycle):
  - valid_out, end_out, act1_out, act2_out = 0; busy = 0.
  - Returns to IDLE, so cmd_ready = 1 two cycles after the end beat was issued.
- abort = 1 sampled in RUN:
  - Next edge goes to IDLE; all beat outputs = 0; no end_out pulse; busy = 0.
  - abort has priority over stall and over the final beat.
  - abort in IDLE or DONE is ignored.
- Simultaneous cmd_valid while busy: not accepted, because cmd_ready = 0; the source must hold the command.
- Reset mid-transfer: immediate return to reset values; the transfer is discarded.
- cmd_len = 1: a single beat with valid_out = 1 and end_out = 1 in the same cycle.

Decomposition:
- Shared package dma_pkg:
  - State encoding constants: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Direction codes DIR_RD = 2'b01 and DIR_WR = 2'b10.
  - ADDR_W default; STRIDE default.
- One natural sub-module, dma_beat_counter: loadable down-counter with enable (stall-gated) and a last flag.
- The FSM and address incrementer stay in the top module.

Test Plan:
- Read, 4 beats (cmd_addr = 0x1000, len = 4, dir = 01, no stall) -> addr_com 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles; valid_out = 1 and act1_out = 1 throughout; end_out = 1 only on 0x1018; cmd_ready returns 2 cycles later.
- Write, 3 beats, stall high on beat 2 for 2 cycles (addr = 0x40, dir = 10) -> beats 0x40, [2 cycles valid_out = 0 with addr held at 0x40], 0x48, 0x50; act2_out = 1; end_out on 0x50; exactly 3 valid beats.
- Wrap: addr = 0xFFFF_FFFF_FFFF_FFF8, len = 2 -> beats at 0xFFFF_FFFF_FFFF_FFF8 then 0x0000_0000_0000_0000; end_out on the second beat; err = 0.
- Illegal commands: len = 0, then dir = 11 -> err pulses one cycle each; valid_out stays 0; busy stays 0; cmd_ready stays 1.
- Abort: len = 8; assert abort after the 3rd beat -> no further valid_out, no end_out pulse; IDLE and cmd_ready = 1 on the next cycle; a new len = 1 command then yields a single beat with end_out = 1.
- Reset mid-transfer: assert reset asynchronously during beat 2 of 5 -> all outputs 0 immediately, without waiting for a clock edge; after release, cmd_ready = 1 and no stale beats.

Source files
------------

// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA address generator slice.
//   state_t      : generator FSM states (IDLE / RUN / DONE)
//   DIR_RD/DIR_WR: command direction codes (read drives act1, write drives act2)
//   *_DEF        : default address width, beat-count width and stride
//   dir_legal()  : true for the two legal direction codes
// ---------------------------------------------------------------------------
package dma_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int LEN_W_DEF  = 16;
    localparam int STRIDE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] DIR_RD = 2'b01;
    localparam logic [1:0] DIR_WR = 2'b10;

    function automatic logic dir_legal(input logic [1:0] dir);
        return (dir == DIR_RD) || (dir == DIR_WR);
    endfunction

endpackage

// File: rtl/dma_addr_gen_if.sv
// ---------------------------------------------------------------------------
// dma_addr_gen_if
// Command channel and beat bus of the DMA address generator.
//   cmd_valid/cmd_ready : command handshake. A command transfers on a rising
//                         edge where both are high; the source holds
//                         cmd_addr/cmd_len/cmd_dir stable while cmd_valid is
//                         high and cmd_ready is low.
//   cmd_addr/len/dir    : start address, beat count, direction code
//   stall               : downstream backpressure, freezes beat issue
//   valid_out, end_out, act1_out, act2_out, addr_com : registered beat bus
// Modports:
//   master : command source / beat consumer
//   slave  : the address generator
// ---------------------------------------------------------------------------
interface dma_addr_gen_if #(
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [1:0]        cmd_dir;
    logic              stall;
    logic              valid_out;
    logic              end_out;
    logic              act1_out;
    logic              act2_out;
    logic [ADDR_W-1:0] addr_com;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_dir, stall,
        input  cmd_ready, valid_out, end_out, act1_out, act2_out, addr_com
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_dir, stall,
        output cmd_ready, valid_out, end_out, act1_out, act2_out, addr_com
    );
endinterface

// File: rtl/dma_beat_counter.sv
// ---------------------------------------------------------------------------
// dma_beat_counter
// Loadable down-counter of remaining beats.
//   clk, reset : clock, asynchronous active-high reset (clears the count)
//   load       : load load_val (has priority over en)
//   load_val   : beat count of the accepted command
//   en         : one beat issued this edge (already stall-gated by caller)
//   last       : remaining count is exactly one, i.e. next beat is the end
// ---------------------------------------------------------------------------
module dma_beat_counter #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             en,
    output logic             last
);
    logic [LEN_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - LEN_W'(1);
        end
    end

    assign last = (count == LEN_W'(1));
endmodule

// File: rtl/dma_addr_gen.sv
// ---------------------------------------------------------------------------
// dma_addr_gen
// Expands one transfer command into a registered per-beat address stream.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : command channel + beat bus (slave side of dma_addr_gen_if)
//   abort      : synchronous cancel, honoured only in RUN
//   busy       : transfer in progress (registered)
//   err        : one-cycle pulse after an illegal command is accepted
//   state_dbg  : current FSM state
// Every output is a register; the always_comb computes the next value of
// each one and the always_ff loads them all on the same edge.
// ---------------------------------------------------------------------------
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int STRIDE = STRIDE_DEF
) (
    input  logic         clk,
    input  logic         reset,
    dma_addr_gen_if.slave bus,
    input  logic         abort,
    output logic         busy,
    output logic         err,
    output state_t       state_dbg
);
    state_t            state, state_n;
    logic              cmd_ready_r, cmd_ready_n;
    logic              valid_r, valid_n;
    logic              end_r, end_n;
    logic              act1_r, act1_n;
    logic              act2_r, act2_n;
    logic [ADDR_W-1:0] addr_com_r, addr_com_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [1:0]        dir_r, dir_n;
    logic              busy_r, busy_n;
    logic              err_n, err_r;
    logic              cnt_load, cnt_en, cnt_last;
    logic              accept, cmd_legal;

    dma_beat_counter #(.LEN_W(LEN_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (bus.cmd_len),
        .en       (cnt_en),
        .last     (cnt_last)
    );

    assign accept    = bus.cmd_valid && cmd_ready_r;
    assign cmd_legal = (bus.cmd_len != '0) && dir_legal(bus.cmd_dir);

    always_comb begin
        state_n     = state;
        cmd_ready_n = cmd_ready_r;
        valid_n     = 1'b0;
        end_n       = 1'b0;
        act1_n      = act1_r;
        act2_n      = act2_r;
        addr_com_n  = addr_com_r;
        addr_n      = addr_r;
        dir_n       = dir_r;
        busy_n      = busy_r;
        err_n       = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;

        case (state)
            IDLE: begin
                // cmd_ready rises one cycle after entering IDLE from DONE,
                // which places it two cycles after the end beat.
                cmd_ready_n = 1'b1;
                act1_n      = 1'b0;
                act2_n      = 1'b0;
                busy_n      = 1'b0;
                if (accept) begin
                    if (cmd_legal) begin
                        state_n     = RUN;
                        cmd_ready_n = 1'b0;
                        busy_n      = 1'b1;
                        addr_n      = bus.cmd_addr;
                        dir_n       = bus.cmd_dir;
                        cnt_load    = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    // Abort wins over stall and over the final beat.
                    state_n     = IDLE;
                    cmd_ready_n = 1'b1;
                    act1_n      = 1'b0;
                    act2_n      = 1'b0;
                    addr_com_n  = '0;
                    busy_n      = 1'b0;
                end else if (!bus.stall) begin
                    valid_n    = 1'b1;
                    addr_com_n = addr_r;
                    act1_n     = (dir_r == DIR_RD);
                    act2_n     = (dir_r == DIR_WR);
                    addr_n     = addr_r + ADDR_W'(STRIDE);
                    cnt_en     = 1'b1;
                    if (cnt_last) begin
                        end_n   = 1'b1;
                        state_n = DONE;
                    end
                end
                // Stalled: valid/end drop by default, everything else holds.
            end

            DONE: begin
                state_n    = IDLE;
                act1_n     = 1'b0;
                act2_n     = 1'b0;
                addr_com_n = '0;
                busy_n     = 1'b0;
            end

            default: begin
                state_n     = IDLE;
                cmd_ready_n = 1'b1;
                act1_n      = 1'b0;
                act2_n      = 1'b0;
                addr_com_n  = '0;
                busy_n      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_ready_r <= 1'b1;
            valid_r     <= 1'b0;
            end_r       <= 1'b0;
            act1_r      <= 1'b0;
            act2_r      <= 1'b0;
            addr_com_r  <= '0;
            addr_r      <= '0;
            dir_r       <= 2'b00;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state       <= state_n;
            cmd_ready_r <= cmd_ready_n;
            valid_r     <= valid_n;
            end_r       <= end_n;
            act1_r      <= act1_n;
            act2_r      <= act2_n;
            addr_com_r  <= addr_com_n;
            addr_r      <= addr_n;
            dir_r       <= dir_n;
            busy_r      <= busy_n;
            err_r       <= err_n;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.valid_out = valid_r;
    assign bus.end_out   = end_r;
    assign bus.act1_out  = act1_r;
    assign bus.act2_out  = act2_r;
    assign bus.addr_com  = addr_com_r;
    assign busy          = busy_r;
    assign err           = err_r;
    assign state_dbg     = state;
endmodule

// File: tb/tb_dma_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_dma_addr_gen
// Directed bench for dma_addr_gen. Each legal command is expanded into its
// expected beats (start + i*8, wrapping at 2^64; end on the last beat; act
// flag from the direction) and queued; a negedge process pops one entry per
// valid beat. Directed checks with literal values cover reset, latency,
// stall, wrap, illegal commands, abort and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_dma_addr_gen;
    import dma_pkg::*;

    logic   clk;
    logic   reset;
    logic   abort;
    logic   busy;
    logic   err;
    state_t state_dbg;

    dma_addr_gen_if #(.ADDR_W(64), .LEN_W(16)) bus ();

    dma_addr_gen #(.ADDR_W(64), .LEN_W(16), .STRIDE(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .abort     (abort),
        .busy      (busy),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    // entry = {end, act1, act2, addr}
    logic [66:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Spec-level expansion of a command into beats.
    task automatic model_cmd(input logic [63:0] a, input logic [15:0] l, input logic [1:0] d);
        logic [63:0] ba;
        if (l != 16'd0 && (d == 2'b01 || d == 2'b10)) begin
            for (int i = 0; i < int'(l); i++) begin
                ba = a + 64'(i) * 64'd8;
                exp_q.push_back({(i == int'(l) - 1), (d == 2'b01), (d == 2'b10), ba});
            end
        end
    endtask

    always @(negedge clk) begin
        logic [66:0] e;
        if (!reset) begin
            if (bus.valid_out) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_addr", bus.addr_com, e[63:0]);
                    check("sb_end",  64'(bus.end_out),  64'(e[66]));
                    check("sb_act1", 64'(bus.act1_out), 64'(e[65]));
                    check("sb_act2", 64'(bus.act2_out), 64'(e[64]));
                end
            end else begin
                check("end_without_valid", 64'(bus.end_out), 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [15:0] l, input logic [1:0] d);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_dir   = d;
        model_cmd(a, l, d);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [63:0] t1_addr [4];

    initial begin
        t1_addr = '{64'h1000, 64'h1008, 64'h1010, 64'h1018};
        reset = 1'b0;
        abort = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_dir   = 2'b00;
        bus.stall     = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        // reset values
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_valid", 64'(bus.valid_out), 64'd0);
        check("rst_end",   64'(bus.end_out), 64'd0);
        check("rst_act",   64'({bus.act1_out, bus.act2_out}), 64'd0);
        check("rst_addr",  bus.addr_com, 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_err",   64'(err), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        reset = 1'b0;
        tick();

        // Read, 4 beats
        send_cmd(64'h1000, 16'd4, 2'b01);
        check("t1_busy",      64'(busy), 64'd1);
        check("t1_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("t1_no_beat",   64'(bus.valid_out), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_addr",  bus.addr_com, t1_addr[i]);
            check("t1_valid", 64'(bus.valid_out), 64'd1);
            check("t1_act",   64'({bus.act1_out, bus.act2_out}), 64'd2);
            check("t1_end",   64'(bus.end_out), 64'(i == 3));
        end
        tick();
        check("t1_done_valid", 64'(bus.valid_out), 64'd0);
        check("t1_done_busy",  64'(busy), 64'd0);
        check("t1_done_ready", 64'(bus.cmd_ready), 64'd0);
        tick();
        check("t1_ready_back", 64'(bus.cmd_ready), 64'd1);

        // Write, 3 beats, stall on beat 2 for two cycles
        send_cmd(64'h40, 16'd3, 2'b10);
        tick();
        check("t2_b1_addr", bus.addr_com, 64'h40);
        check("t2_b1_act2", 64'(bus.act2_out), 64'd1);
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t2_stall_valid", 64'(bus.valid_out), 64'd0);
            check("t2_stall_addr",  bus.addr_com, 64'h40);
            check("t2_stall_act2",  64'(bus.act2_out), 64'd1);
        end
        bus.stall = 1'b0;
        tick();
        check("t2_b2_addr", bus.addr_com, 64'h48);
        check("t2_b2_end",  64'(bus.end_out), 64'd0);
        tick();
        check("t2_b3_addr", bus.addr_com, 64'h50);
        check("t2_b3_end",  64'(bus.end_out), 64'd1);
        tick();
        check("t2_all_beats", 64'(exp_q.size()), 64'd0);

        // Address wrap
        send_cmd(64'hFFFF_FFFF_FFFF_FFF8, 16'd2, 2'b01);
        tick();
        check("t3_b1_addr", bus.addr_com, 64'hFFFF_FFFF_FFFF_FFF8);
        check("t3_b1_end",  64'(bus.end_out), 64'd0);
        tick();
        check("t3_b2_addr", bus.addr_com, 64'h0);
        check("t3_b2_end",  64'(bus.end_out), 64'd1);
        check("t3_err",     64'(err), 64'd0);

        // Illegal commands
        send_cmd(64'h100, 16'd0, 2'b01);
        check("t4_len0_err",   64'(err), 64'd1);
        check("t4_len0_ready", 64'(bus.cmd_ready), 64'd1);
        check("t4_len0_busy",  64'(busy), 64'd0);
        tick();
        check("t4_len0_err_drop", 64'(err), 64'd0);
        send_cmd(64'h100, 16'd4, 2'b11);
        check("t4_dir11_err",   64'(err), 64'd1);
        check("t4_dir11_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        check("t4_dir11_err_drop", 64'(err), 64'd0);
        check("t4_dir11_valid",    64'(bus.valid_out), 64'd0);
        check("t4_dir11_busy",     64'(busy), 64'd0);

        // Abort after the 3rd beat
        send_cmd(64'h3000, 16'd8, 2'b01);
        tick();
        tick();
        tick();
        check("t5_b3_addr", bus.addr_com, 64'h3010);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        check("t5_abort_valid", 64'(bus.valid_out), 64'd0);
        check("t5_abort_end",   64'(bus.end_out), 64'd0);
        check("t5_abort_busy",  64'(busy), 64'd0);
        check("t5_abort_ready", 64'(bus.cmd_ready), 64'd1);
        check("t5_abort_state", 64'(state_dbg), 64'(IDLE));
        tick();
        tick();
        check("t5_quiet", 64'(bus.valid_out), 64'd0);
        send_cmd(64'h5000, 16'd1, 2'b10);
        tick();
        check("t5_single_valid", 64'(bus.valid_out), 64'd1);
        check("t5_single_end",   64'(bus.end_out), 64'd1);
        check("t5_single_addr",  bus.addr_com, 64'h5000);
        tick();
        check("t5_single_after", 64'(bus.valid_out), 64'd0);

        // Asynchronous reset during beat 2 of 5
        send_cmd(64'h2000, 16'd5, 2'b01);
        tick();
        tick();
        check("t6_b2_addr", bus.addr_com, 64'h2008);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        check("t6_rst_valid", 64'(bus.valid_out), 64'd0);
        check("t6_rst_addr",  bus.addr_com, 64'd0);
        check("t6_rst_act1",  64'(bus.act1_out), 64'd0);
        check("t6_rst_busy",  64'(busy), 64'd0);
        check("t6_rst_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("t6_post_ready", 64'(bus.cmd_ready), 64'd1);
        check("t6_post_valid", 64'(bus.valid_out), 64'd0);
        check("t6_post_state", 64'(state_dbg), 64'(IDLE));

        tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
